// File: rtl/commit_store_queue_pkg.sv
// Shared types and defaults for the commit-stage store queue.
// Entries carry everything the D$ write port needs.
package commit_store_queue_pkg;

   localparam int unsigned PLEN                 = 56;
   localparam int unsigned XLEN                 = 64;
   localparam int unsigned DEFAULT_DEPTH_SPEC   = 4;
   localparam int unsigned DEFAULT_DEPTH_COMMIT = 8;

   typedef struct packed {
      logic [PLEN-1:0]   paddr;
      logic [XLEN-1:0]   data;
      logic [XLEN/8-1:0] be;
      logic [1:0]        size;
   } store_entry_t;

   typedef enum logic {
      DRAIN_IDLE = 1'b0,
      DRAIN_REQ  = 1'b1
   } drain_state_e;

   // Loads hazard against a store when they share the same 8-byte word in the page.
   function automatic logic offset_hit(store_entry_t e, logic [11:0] page_offset);
      return e.paddr[11:3] == page_offset[11:3];
   endfunction

endpackage

// File: rtl/commit_store_queue_sb_queue.sv
// Circular store buffer with push/pop/clear, exposing every slot and its
// liveness so the owner can run an address compare across the whole buffer.
module sb_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = logic [7:0]
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  entry_t                   data_i,
   output entry_t                   head_o,
   output logic [$clog2(DEPTH):0]   cnt_o,
   output logic                     empty_o,
   output entry_t                   entries_o [DEPTH],
   output logic [DEPTH-1:0]         valid_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          full, do_push, do_pop;

   assign full    = cnt_q == (PW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full && !clear_i;
   assign do_pop  = pop_i && !empty_o;

   // A clear that coincides with a pop keeps the pop, then collapses the tail onto the new head.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (do_pop)  head_d = head_q + 1'b1;
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
      if (clear_i) begin
         tail_d = head_d;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         if (do_push) mem_q[tail_q] <= data_i;
      end
   end

   // A slot is live when its distance from head is below the count, so cleared slots never match.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_o[i] = {1'b0, PW'(i) - head_q} < cnt_q;
      end
   end

   assign head_o    = mem_q[head_q];
   assign cnt_o     = cnt_q;
   assign entries_o = mem_q;

endmodule

// File: rtl/commit_store_queue.sv
// Speculative + committed store queues with a req/gnt drain to the D$.
// valid/ready: a transfer happens in any cycle where both are 1 at the clock edge.
module commit_store_queue
   import commit_store_queue_pkg::*;
#(
   parameter int unsigned DEPTH_SPEC   = DEFAULT_DEPTH_SPEC,
   parameter int unsigned DEPTH_COMMIT = DEFAULT_DEPTH_COMMIT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [PLEN-1:0]   paddr_i,
   input  logic [XLEN-1:0]   data_i,
   input  logic [XLEN/8-1:0] be_i,
   input  logic [1:0]        size_i,
   output logic              ready_o,
   input  logic              commit_i,
   output logic              commit_ready_o,
   output logic              no_st_pending_o,
   input  logic [11:0]       page_offset_i,
   output logic              page_offset_match_o,
   output logic              req_o,
   output logic [PLEN-1:0]   addr_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic [XLEN/8-1:0] be_o,
   output logic [1:0]        size_o,
   input  logic              gnt_i
);

   localparam int unsigned SW = $clog2(DEPTH_SPEC);
   localparam int unsigned CW = $clog2(DEPTH_COMMIT);

   store_entry_t          alloc_entry, spec_head, com_head;
   store_entry_t          spec_entries [DEPTH_SPEC];
   store_entry_t          com_entries  [DEPTH_COMMIT];
   logic [DEPTH_SPEC-1:0]   spec_valid;
   logic [DEPTH_COMMIT-1:0] com_valid;
   logic [SW:0]           spec_cnt;
   logic [CW:0]           com_cnt, com_cnt_next;
   logic                  spec_empty, com_empty;
   logic                  spec_push, commit_ok, drain_pop;
   drain_state_e          state_q;

   assign alloc_entry    = '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};
   assign ready_o        = spec_cnt < (SW+1)'(DEPTH_SPEC);
   assign commit_ready_o = com_cnt < (CW+1)'(DEPTH_COMMIT);
   assign spec_push      = valid_i && ready_o && !flush_i;
   assign commit_ok      = commit_i && !spec_empty && commit_ready_o;
   assign drain_pop      = (state_q == DRAIN_REQ) && gnt_i;

   sb_queue #(.DEPTH(DEPTH_SPEC), .entry_t(store_entry_t)) i_spec_q (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(spec_push), .pop_i(commit_ok), .clear_i(flush_i),
      .data_i(alloc_entry), .head_o(spec_head), .cnt_o(spec_cnt), .empty_o(spec_empty),
      .entries_o(spec_entries), .valid_o(spec_valid)
   );

   sb_queue #(.DEPTH(DEPTH_COMMIT), .entry_t(store_entry_t)) i_com_q (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(commit_ok), .pop_i(drain_pop), .clear_i(1'b0),
      .data_i(spec_head), .head_o(com_head), .cnt_o(com_cnt), .empty_o(com_empty),
      .entries_o(com_entries), .valid_o(com_valid)
   );

   always_comb begin
      com_cnt_next = com_cnt;
      if (commit_ok && !drain_pop)      com_cnt_next = com_cnt + 1'b1;
      else if (!commit_ok && drain_pop) com_cnt_next = com_cnt - 1'b1;
   end

   // Deciding on the next count lets req rise the cycle after a commit and keeps grants back-to-back.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= DRAIN_IDLE;
      end else begin
         case (state_q)
            DRAIN_IDLE: if (com_cnt_next != '0) state_q <= DRAIN_REQ;
            DRAIN_REQ:  if (gnt_i && com_cnt_next == '0) state_q <= DRAIN_IDLE;
            default:    state_q <= DRAIN_IDLE;
         endcase
      end
   end

   assign req_o           = state_q == DRAIN_REQ;
   assign addr_o          = req_o ? com_head.paddr : '0;
   assign wdata_o         = req_o ? com_head.data  : '0;
   assign be_o            = req_o ? com_head.be    : '0;
   assign size_o          = req_o ? com_head.size  : '0;
   assign no_st_pending_o = com_empty && (state_q == DRAIN_IDLE);

   always_comb begin
      page_offset_match_o = 1'b0;
      for (int i = 0; i < DEPTH_SPEC; i++) begin
         if (spec_valid[i] && offset_hit(spec_entries[i], page_offset_i)) page_offset_match_o = 1'b1;
      end
      for (int i = 0; i < DEPTH_COMMIT; i++) begin
         if (com_valid[i] && offset_hit(com_entries[i], page_offset_i)) page_offset_match_o = 1'b1;
      end
   end

`ifndef SYNTHESIS
   commit_protocol_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      commit_i |-> (!spec_empty && commit_ready_o))
      else $error("commit_i with empty speculative queue or full committed queue");
`endif

endmodule
